// File: rtl/some_module_pkg.sv
// Shared widths, limits and FSM state type for the some_module tick timer.
package some_module_pkg;
  localparam int CNT_W  = 8;
  localparam int WRAP_W = 16;
  localparam int P_MAX  = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/some_module_wrap_cnt.sv
// Saturating counter of issued ticks; holds at all-ones once full.
module some_module_wrap_cnt
  import some_module_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [WRAP_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WRAP_W{1'b1}})) begin
      count <= count + WRAP_W'(1);
    end
  end

endmodule

// File: rtl/some_module.sv
// Programmable-period tick timer (one-shot or periodic) with IDLE/RUN/DONE FSM.
// Define SOME_MODULE_WRAP_CNT_EN to build the saturating wrap counter behind wraps_o.
module some_module
  import some_module_pkg::*;
#(
  parameter bit SOME_BIT_PARAM       = 1'b0,
  parameter int SOME_OTHER_INT_PARAM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  output logic [CNT_W-1:0]  count_o,
  output logic              tick_o,
  output logic              busy_o,
  output logic [WRAP_W-1:0] wraps_o,
  output state_t            state_dbg
);

  if ((SOME_OTHER_INT_PARAM < 1) || (SOME_OTHER_INT_PARAM > P_MAX)) begin : g_bad_period
    $error("some_module: SOME_OTHER_INT_PARAM must be in 1..255");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SOME_OTHER_INT_PARAM - 1);

  state_t state_q;

  assign busy_o    = (state_q == RUN);
  assign state_dbg = state_q;

  // start outranks a coincident wrap, so a restart never emits a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_o <= '0;
      tick_o  <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      if (start) begin
        state_q <= RUN;
        count_o <= '0;
      end else if ((state_q == RUN) && en) begin
        if (count_o == LAST) begin
          count_o <= '0;
          tick_o  <= 1'b1;
          if (!SOME_BIT_PARAM) state_q <= DONE;
        end else begin
          count_o <= count_o + CNT_W'(1);
        end
      end
    end
  end

`ifdef SOME_MODULE_WRAP_CNT_EN
  logic wrap_hit;
  assign wrap_hit = (state_q == RUN) && en && !start && (count_o == LAST);

  some_module_wrap_cnt u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrap_hit),
    .count (wraps_o)
  );
`else
  assign wraps_o = '0;
`endif

endmodule

// File: tb/tb_some_module.sv
// Bench for some_module: three instances (periodic P=18, one-shot P=18, periodic P=1) on shared stimulus.
module tb_some_module;
  import some_module_pkg::*;

  logic clk = 1'b0;
  logic rst, en, start;
  always #5 clk = ~clk;

  logic [7:0]  cnt_a, cnt_b, cnt_c;
  logic        tick_a, tick_b, tick_c;
  logic        busy_a, busy_b, busy_c;
  logic [15:0] wr_a, wr_b, wr_c;
  state_t      st_a, st_b, st_c;

  some_module #(.SOME_BIT_PARAM(1'b1), .SOME_OTHER_INT_PARAM(18)) dut_a (
    .clk(clk), .rst(rst), .en(en), .start(start), .count_o(cnt_a), .tick_o(tick_a),
    .busy_o(busy_a), .wraps_o(wr_a), .state_dbg(st_a));
  some_module #(.SOME_BIT_PARAM(1'b0), .SOME_OTHER_INT_PARAM(18)) dut_b (
    .clk(clk), .rst(rst), .en(en), .start(start), .count_o(cnt_b), .tick_o(tick_b),
    .busy_o(busy_b), .wraps_o(wr_b), .state_dbg(st_b));
  some_module #(.SOME_BIT_PARAM(1'b1), .SOME_OTHER_INT_PARAM(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .start(start), .count_o(cnt_c), .tick_o(tick_c),
    .busy_o(busy_c), .wraps_o(wr_c), .state_dbg(st_c));

  // Observed word per instance: {count, tick, busy, wraps}.
  logic [25:0] obs [3];
  assign obs[0] = {cnt_a, tick_a, busy_a, wr_a};
  assign obs[1] = {cnt_b, tick_b, busy_b, wr_b};
  assign obs[2] = {cnt_c, tick_c, busy_c, wr_c};

  logic [25:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state, one slot per instance (0 IDLE, 1 RUN, 2 DONE).
  bit          m_per [3] = '{1'b1, 1'b0, 1'b1};
  int          m_p   [3] = '{18, 18, 1};
  int          m_st  [3];
  logic [7:0]  m_cnt [3];
  logic        m_tick[3];
  logic [15:0] m_wr  [3];

  task automatic drive(input logic r, input logic s, input logic e);
    rst = r; start = s; en = e;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_st[i] = 0; m_cnt[i] = '0; m_tick[i] = 1'b0; m_wr[i] = '0;
      end else begin
        m_tick[i] = 1'b0;
        if (s) begin
          m_st[i] = 1; m_cnt[i] = '0;
        end else if (m_st[i] == 1 && e) begin
          if (int'(m_cnt[i]) == m_p[i] - 1) begin
            m_cnt[i]  = '0;
            m_tick[i] = 1'b1;
`ifdef SOME_MODULE_WRAP_CNT_EN
            if (m_wr[i] != 16'hFFFF) m_wr[i] = m_wr[i] + 16'd1;
`endif
            if (!m_per[i]) m_st[i] = 2;
          end else begin
            m_cnt[i] = m_cnt[i] + 8'd1;
          end
        end
      end
      exp_q.push_back({m_cnt[i], m_tick[i], (m_st[i] == 1), m_wr[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [25:0] exp;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (obs[i] !== exp) $display("FAIL reset inst%0d k=%0d: got %h want %h", i, k, obs[i], exp);
        else n_pass++;
      end
    end
    n_checks++;
    if ({obs[0], obs[1], obs[2]} !== 78'd0) $display("FAIL reset_zero: got %h %h %h want 0", obs[0], obs[1], obs[2]);
    else n_pass++;
  endtask

  task automatic test_periodic();
    logic [25:0] exp;
    int ta[$];
    int tb[$];
    for (int k = 0; k <= 60; k++) begin
      drive(1'b0, k == 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (obs[i] !== exp) $display("FAIL periodic inst%0d k=%0d: got %h want %h", i, k, obs[i], exp);
        else n_pass++;
      end
      if (tick_a) ta.push_back(k);
      if (tick_b) tb.push_back(k);
    end
    n_checks++;
    if (ta.size() == 3 && ta[0] == 18 && ta[1] == 36 && ta[2] == 54) n_pass++;
    else $display("FAIL periodic_ticks: got %p want 18,36,54", ta);
    n_checks++;
    if (tb.size() == 1 && tb[0] == 18) n_pass++;
    else $display("FAIL oneshot_tick: got %p want 18", tb);
    n_checks++;
    if (busy_b !== 1'b0 || cnt_b !== 8'd0 || st_b !== DONE)
      $display("FAIL oneshot_done: got busy=%b cnt=%0d st=%0d want 0 0 DONE", busy_b, cnt_b, st_b);
    else n_pass++;
  endtask

  task automatic test_oneshot_restart();
    logic [25:0] exp;
    int tb[$];
    for (int k = 0; k <= 24; k++) begin
      drive(1'b0, k == 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (obs[i] !== exp) $display("FAIL restart inst%0d k=%0d: got %h want %h", i, k, obs[i], exp);
        else n_pass++;
      end
      if (tick_b) tb.push_back(k);
    end
    n_checks++;
    if (tb.size() == 1 && tb[0] == 18) n_pass++;
    else $display("FAIL restart_tick: got %p want 18", tb);
  endtask

  task automatic test_en_hold();
    logic [25:0] exp;
    int ta[$];
    logic [7:0] held;
    for (int k = 0; k <= 30; k++) begin
      drive(1'b0, k == 0, !(k >= 11 && k <= 15));
      for (int i = 0; i < 3; i++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (obs[i] !== exp) $display("FAIL en_hold inst%0d k=%0d: got %h want %h", i, k, obs[i], exp);
        else n_pass++;
      end
      if (k == 15) held = cnt_a;
      if (tick_a) ta.push_back(k);
    end
    n_checks++;
    if (held !== 8'd10) $display("FAIL en_hold_count: got %0d want 10", held);
    else n_pass++;
    n_checks++;
    if (ta.size() == 1 && ta[0] == 23) n_pass++;
    else $display("FAIL en_hold_tick: got %p want 23", ta);
  endtask

  task automatic test_start_override();
    logic [25:0] exp;
    logic [15:0] wr_before;
    for (int k = 0; k <= 22; k++) begin
      if (k == 18) wr_before = wr_a;
      drive(1'b0, (k == 0) || (k == 18), 1'b1);
      for (int i = 0; i < 3; i++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (obs[i] !== exp) $display("FAIL override inst%0d k=%0d: got %h want %h", i, k, obs[i], exp);
        else n_pass++;
      end
      if (k == 18) begin
        n_checks++;
        if (cnt_a !== 8'd0 || tick_a !== 1'b0 || wr_a !== wr_before || busy_a !== 1'b1)
          $display("FAIL override_wrap: got cnt=%0d tick=%b wraps=%0d want 0 0 %0d", cnt_a, tick_a, wr_a, wr_before);
        else n_pass++;
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [25:0] exp;
    for (int k = 0; k <= 15; k++) begin
      drive(k == 10, k == 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (obs[i] !== exp) $display("FAIL rst_mid inst%0d k=%0d: got %h want %h", i, k, obs[i], exp);
        else n_pass++;
      end
      if (k == 10) begin
        n_checks++;
        if (obs[0] !== 26'd0) $display("FAIL rst_mid_zero: got %h want 0", obs[0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (busy_a !== 1'b0 || st_a !== IDLE || cnt_a !== 8'd0)
      $display("FAIL rst_mid_idle: got busy=%b st=%0d cnt=%0d want 0 IDLE 0", busy_a, st_a, cnt_a);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [25:0] exp;
    logic [15:0] want;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) void'(exp_q.pop_front());
    for (int k = 0; k <= 65540; k++) begin
      drive(1'b0, k == 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (obs[i] !== exp) $display("FAIL saturate inst%0d k=%0d: got %h want %h", i, k, obs[i], exp);
        else n_pass++;
      end
    end
`ifdef SOME_MODULE_WRAP_CNT_EN
    want = 16'hFFFF;
`else
    want = 16'h0000;
`endif
    n_checks++;
    if (wr_c !== want || tick_c !== 1'b1) $display("FAIL saturate_final: got wraps=%h tick=%b want %h 1", wr_c, tick_c, want);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; en = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot_restart();
    test_en_hold();
    test_start_override();
    test_rst_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
